// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse_sched sequencer: FSM state
// encodings, default amplitude width and jitter LFSR constants.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int PULSE_DW = 14;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/pulse_sched_lfsr.sv
// 8-bit Fibonacci LFSR used to jitter the inter-pulse gap.
// Ports: clk, rst (async, active-high), en (advance), q (state).
module pulse_sched_lfsr
  import pulse_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);
  assign q    = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= LFSR_SEED;
    end else if (en) begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Sequencer driving genPulse load/val/sel from a small amplitude/shape
// table, with a programmable gap between loads; single-shot or looping.
// Ports: clk, rst (async, active-high); cfg_we/addr/amp/sel table write;
//   cfg_last/gap/loop run setup (latched at start); start, stop;
//   gen_load/val/sel to genPulse; busy, done, pulse_idx, pulse_cnt status.
// Optional: PULSE_SCHED_JITTER_EN adds cfg_jmask and an LFSR gap jitter.
module pulse_sched
  import pulse_pkg::*;
#(
  parameter int DW    = PULSE_DW,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_amp,
  input  logic [3:0]    cfg_sel,
  input  logic [AW-1:0] cfg_last,
  input  logic [CW-1:0] cfg_gap,
  input  logic          cfg_loop,
`ifdef PULSE_SCHED_JITTER_EN
  input  logic [7:0]    cfg_jmask,
`endif
  input  logic          start,
  input  logic          stop,
  output logic          gen_load,
  output logic [DW-1:0] gen_val,
  output logic [3:0]    gen_sel,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pulse_idx,
  output logic [15:0]   pulse_cnt
);

  logic [DW-1:0] r_amp [DEPTH];
  logic [3:0]    r_tsel [DEPTH];

  state_t        r_state;
  logic          r_gen_load;
  logic [DW-1:0] r_gen_val;
  logic [3:0]    r_gen_sel;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_idx;
  logic [15:0]   r_pulse_cnt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_gap;
  logic [AW-1:0] r_last;
  logic          r_loop;

  logic          w_not_last;
  logic          w_more;
  logic [AW-1:0] w_next_idx;
  logic [CW-1:0] w_gap_ld;

  assign gen_load  = r_gen_load;
  assign gen_val   = r_gen_val;
  assign gen_sel   = r_gen_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_idx = r_idx;
  assign pulse_cnt = r_pulse_cnt;

  assign w_not_last = (r_idx < r_last);
  assign w_more     = w_not_last || r_loop;
  assign w_next_idx = w_not_last ? r_idx + 1'b1 : '0;

`ifdef PULSE_SCHED_JITTER_EN
  logic [7:0]  w_lfsr;
  logic        w_lfsr_en;
  logic [CW:0] w_gap_sum;

  assign w_lfsr_en = (r_state == ST_LOAD);

  pulse_sched_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_lfsr_en),
    .q   (w_lfsr)
  );

  // One extra bit catches overflow so the gap saturates instead of
  // wrapping round to a short one.
  assign w_gap_sum = {1'b0, r_gap}
                   + {{(CW-7){1'b0}}, (w_lfsr & cfg_jmask)};
  assign w_gap_ld  = w_gap_sum[CW] ? '1 : w_gap_sum[CW-1:0];
`else
  assign w_gap_ld = r_gap;
`endif

  // Table is frozen outside IDLE; not reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && cfg_we) begin
      r_amp[cfg_addr]  <= cfg_amp;
      r_tsel[cfg_addr] <= cfg_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gen_load  <= 1'b0;
      r_gen_val   <= '0;
      r_gen_sel   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_idx       <= '0;
      r_pulse_cnt <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_last      <= '0;
      r_loop      <= 1'b0;
    end else begin
      r_gen_load <= 1'b0;
      r_done     <= 1'b0;
      if (stop && r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start && !cfg_we) begin
              r_gap       <= cfg_gap;
              r_last      <= cfg_last;
              r_loop      <= cfg_loop;
              r_idx       <= '0;
              // Count includes the load issued on this transition.
              r_pulse_cnt <= 16'd1;
              r_gen_load  <= 1'b1;
              r_gen_val   <= r_amp[0];
              r_gen_sel   <= r_tsel[0];
              r_busy      <= 1'b1;
              r_state     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            r_cnt   <= w_gap_ld;
            r_state <= ST_GAP;
          end
          ST_GAP: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (w_more) begin
              r_idx       <= w_next_idx;
              r_pulse_cnt <= r_pulse_cnt + 16'd1;
              r_gen_load  <= 1'b1;
              r_gen_val   <= r_amp[w_next_idx];
              r_gen_sel   <= r_tsel[w_next_idx];
              r_state     <= ST_LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Self-checking bench for pulse_sched: vector table of runs plus
// hand sequences for stop, async reset and write/start collisions.
module tb_pulse_sched;

  localparam int DW    = 14;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_amp;
  logic [3:0]    cfg_sel;
  logic [AW-1:0] cfg_last;
  logic [CW-1:0] cfg_gap;
  logic          cfg_loop;
`ifdef PULSE_SCHED_JITTER_EN
  logic [7:0]    cfg_jmask;
  logic [7:0]    m_lfsr;
`endif
  logic          start;
  logic          stop;
  logic          gen_load;
  logic [DW-1:0] gen_val;
  logic [3:0]    gen_sel;
  logic          busy;
  logic          done;
  logic [AW-1:0] pulse_idx;
  logic [15:0]   pulse_cnt;

  always #5 clk = ~clk;

  pulse_sched #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_amp   (cfg_amp),
    .cfg_sel   (cfg_sel),
    .cfg_last  (cfg_last),
    .cfg_gap   (cfg_gap),
    .cfg_loop  (cfg_loop),
`ifdef PULSE_SCHED_JITTER_EN
    .cfg_jmask (cfg_jmask),
`endif
    .start     (start),
    .stop      (stop),
    .gen_load  (gen_load),
    .gen_val   (gen_val),
    .gen_sel   (gen_sel),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx),
    .pulse_cnt (pulse_cnt)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] val;
    logic [3:0]    sel;
    logic [AW-1:0] idx;
    logic [15:0]   cnt;
  } ld_t;

  typedef struct {
    logic [AW-1:0] last;
    logic [CW-1:0] gap;
    logic          loop;
    int            nloads;
    logic [7:0]    jmask;
    logic          poke;
    logic          exp_done;
    logic [15:0]   exp_cnt;
  } vec_t;

  ld_t           ldq[$];
  ld_t           dq[$];
  logic [DW-1:0] m_amp [DEPTH];
  logic [3:0]    m_sel [DEPTH];
  vec_t          vecs [6];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic          saw_done;

  function automatic vec_t mkv(input int last, input int gap,
                               input int loop, input int n,
                               input int jm, input int poke,
                               input int ed, input int ec);
    vec_t v;
    v.last     = AW'(last);
    v.gap      = CW'(gap);
    v.loop     = 1'(loop);
    v.nloads   = n;
    v.jmask    = 8'(jm);
    v.poke     = 1'(poke);
    v.exp_done = 1'(ed);
    v.exp_cnt  = 16'(ec);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Advance one clock and check any load/done against the scoreboard.
  task automatic tick();
    ld_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (gen_load) begin
      n_tests++;
      if (ldq.size() == 0) begin
        n_fail++;
        $display("FAIL load_unexpected cyc=%0d idx=%0d required none",
                 cyc, pulse_idx);
      end else begin
        e = ldq.pop_front();
        if (cyc != e.cyc || gen_val !== e.val || gen_sel !== e.sel ||
            pulse_idx !== e.idx || pulse_cnt !== e.cnt || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL load got cyc=%0d val=%0d sel=%0d idx=%0d cnt=%0d busy=%0b required cyc=%0d val=%0d sel=%0d idx=%0d cnt=%0d busy=1",
                   cyc, gen_val, gen_sel, pulse_idx, pulse_cnt, busy,
                   e.cyc, e.val, e.sel, e.idx, e.cnt);
        end
      end
    end
    if (done) begin
      n_tests++;
      saw_done = 1'b1;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected cyc=%0d required none", cyc);
      end else begin
        e = dq.pop_front();
        if (cyc != e.cyc || busy !== 1'b0 ||
            gen_val !== e.val || gen_sel !== e.sel) begin
          n_fail++;
          $display("FAIL done got cyc=%0d busy=%0b val=%0d sel=%0d required cyc=%0d busy=0 val=%0d sel=%0d",
                   cyc, busy, gen_val, gen_sel, e.cyc, e.val, e.sel);
        end
      end
    end
  endtask

  function automatic int eff_gap(input vec_t v);
`ifdef PULSE_SCHED_JITTER_EN
    int s;
    s = int'(v.gap) + int'(m_lfsr & v.jmask);
    if (s > 65535) s = 65535;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    return s;
`else
    return int'(v.gap);
`endif
  endfunction

  task automatic push_run(input vec_t v, input int c1,
                          output int last_c, output int end_c);
    ld_t e;
    int  idx;
    int  t;
    idx    = 0;
    t      = c1;
    last_c = c1;
    e.cyc = 0; e.val = '0; e.sel = '0; e.idx = '0; e.cnt = '0;
    for (int k = 0; k < v.nloads; k++) begin
      e.cyc  = t;
      e.val  = m_amp[idx];
      e.sel  = m_sel[idx];
      e.idx  = idx[AW-1:0];
      e.cnt  = 16'(k + 1);
      ldq.push_back(e);
      last_c = t;
      t      = t + eff_gap(v) + 2;
      if (idx < int'(v.last)) idx++;
      else idx = 0;
    end
    end_c = t;
    if (!v.loop && v.nloads == int'(v.last) + 1) begin
      e.cyc = t;
      dq.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int last_c;
    int end_c;
    cfg_last = v.last;
    cfg_gap  = v.gap;
    cfg_loop = v.loop;
`ifdef PULSE_SCHED_JITTER_EN
    cfg_jmask = v.jmask;
`endif
    saw_done = 1'b0;
    start    = 1'b1;
    push_run(v, cyc + 1, last_c, end_c);
    tick();
    start = 1'b0;
    if (v.poke) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'd1;
      cfg_amp  = 14'd555;
      cfg_sel  = 4'd9;
      tick();
      cfg_we = 1'b0;
    end
    if (v.loop) begin
      while (cyc < last_c) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (4) tick();
    end else begin
      while (cyc < end_c + 3) tick();
    end
    chk({name, "_loads_left"}, ldq.size(), 0);
    chk({name, "_done_left"}, dq.size(), 0);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_done_seen"}, saw_done, v.exp_done);
    chk({name, "_cnt_end"}, pulse_cnt, v.exp_cnt);
    ldq.delete();
    dq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lc;
    int   ec;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_amp = '0;
    cfg_sel = '0; cfg_last = '0; cfg_gap = '0; cfg_loop = 1'b0;
    start = 1'b0; stop = 1'b0; saw_done = 1'b0;
`ifdef PULSE_SCHED_JITTER_EN
    cfg_jmask = '0;
    m_lfsr    = 8'hA5;
`endif
    #2;
    chk("rst_gen_load", gen_load, 0);
    chk("rst_gen_val", gen_val, 0);
    chk("rst_gen_sel", gen_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse_idx", pulse_idx, 0);
    chk("rst_pulse_cnt", pulse_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      m_amp[i] = (i == 0) ? 14'd8191 : (i == 1) ? 14'd4000 :
                 (i == 2) ? 14'd100 : 14'(i * 700 + 13);
      m_sel[i] = (i < 3) ? 4'(i + 1) : 4'(i);
      cfg_we   = 1'b1;
      cfg_addr = AW'(i);
      cfg_amp  = m_amp[i];
      cfg_sel  = m_sel[i];
      tick();
    end
    cfg_we = 1'b0;
    tick();

    //            last gap   loop n  jm poke done cnt
    vecs[0] = mkv(2,   3,    0,   3, 0, 0,   1,   3);
    vecs[1] = mkv(0,   0,    1,  10, 0, 0,   0,  10);
    vecs[2] = mkv(3,   1,    1,   9, 0, 0,   0,   9);
    vecs[3] = mkv(15,  0,    0,  16, 0, 0,   1,  16);
    vecs[4] = mkv(1,   7,    0,   2, 0, 1,   1,   2);
    vecs[5] = mkv(3,   2,    0,   4, 0, 0,   1,   4);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end
    // Entry 1 must still hold its pre-run value.
    run_vec(vecs[0], "frozen_tbl");

    // start together with cfg_we: write lands, no run starts.
    cfg_we   = 1'b1;
    start    = 1'b1;
    cfg_addr = 4'd3;
    cfg_amp  = 14'd1234;
    cfg_sel  = 4'd7;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    m_amp[3] = 14'd1234;
    m_sel[3] = 4'd7;
    chk("we_start_busy", busy, 0);
    chk("we_start_load", gen_load, 0);
    repeat (3) tick();
    run_vec(vecs[5], "we_start_play");

    // stop with simultaneous start in the middle of GAP.
    v = mkv(2, 5, 0, 1, 0, 0, 0, 1);
    cfg_last = v.last; cfg_gap = v.gap; cfg_loop = v.loop;
    saw_done = 1'b0;
    start = 1'b1;
    push_run(v, cyc + 1, lc, ec);
    tick();
    start = 1'b0;
    tick();
    tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_load", gen_load, 0);
    repeat (12) tick();
    chk("stop_no_done", saw_done, 0);
    chk("stop_loads_left", ldq.size(), 0);
    ldq.delete();
    dq.delete();

    // Async reset while in LOAD.
    v = mkv(2, 3, 0, 1, 0, 0, 0, 1);
    cfg_last = v.last; cfg_gap = v.gap; cfg_loop = v.loop;
    start = 1'b1;
    push_run(v, cyc + 1, lc, ec);
    tick();
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_gen_load", gen_load, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gen_val", gen_val, 0);
    chk("arst_pulse_cnt", pulse_cnt, 0);
`ifdef PULSE_SCHED_JITTER_EN
    m_lfsr = 8'hA5;
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("arst_loads_left", ldq.size(), 0);
    ldq.delete();
    dq.delete();
    run_vec(vecs[0], "arst_restart");

`ifdef PULSE_SCHED_JITTER_EN
    rst    = 1'b1;
    m_lfsr = 8'hA5;
    tick();
    rst = 1'b0;
    tick();
    run_vec(mkv(2, 3, 0, 3, 8'h00, 0, 1, 3), "jit_mask0");
    run_vec(mkv(0, 65530, 0, 1, 8'h0F, 0, 1, 1), "jit_sat");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
